rvfi_bus_dmem_fault_region_check: RTL
=====================================

# rvfi_bus_dmem_fault_region_check

Parametrised formal check for data-bus fault propagation. It generalises single-word fault checking to a fault region of `REGION_BYTES`, and adds a persistent or fault-once injection mode. It tracks pending faults sequentially, with an optional retire-latency bound. It sits beside the core in the riscv-formal harness, between the RVFI/RVFI-bus taps and the harness `assume`/`assert` layer.

## Interface
Parameters:
- `NRET`, 1: retire channels.
- `NBUS`, 1: bus channels.
- `XLEN`, 32: address/data width.
- `BUSLEN`, 32: bus data width; `BUSLEN/8` byte lanes.
- `REGION_BYTES`, 4: fault region size; power of two, ≥1.
- `MODE`, 0: fault mode.
  - 0 = persistent: every overlapping bus access faults.
  - 1 = fault-once: only the first overlapping access faults.
- `MAX_LATENCY`, 0: maximum cycles from an injected fault to the matching retire. 0 disables the bound.
- `CHECK_MEM_FAULT`, 1: check `rvfi_mem_fault`.
- `CHECK_MCAUSE`, 1: check mcause.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `check`, in, 1: enables retire checks this cycle.
- `fault_base`, in, XLEN: region base. Tied to a random constant; stable; aligned to `REGION_BYTES`.
- `rvfi_valid`, `rvfi_trap`, `rvfi_mem_fault`, in, NRET each.
- `rvfi_mem_addr`, in, NRET*XLEN.
- `rvfi_mem_rmask`, `rvfi_mem_wmask`, in, NRET*XLEN/8 each.
- `rvfi_csr_mcause_wmask`, `rvfi_csr_mcause_wdata`, in, NRET*XLEN each.
- `rvfi_bus_valid`, `rvfi_bus_data`, `rvfi_bus_fault`, in, NBUS each.
- `rvfi_bus_addr`, in, NBUS*XLEN.
- `rvfi_bus_rmask`, `rvfi_bus_wmask`, in, NBUS*BUSLEN/8 each.
- `fault_req`, out, NBUS: combinational. The harness assumes `rvfi_bus_fault[c] == fault_req[c]` whenever `rvfi_bus_valid[c] && rvfi_bus_data[c]`.
- `state`, out, 2: FSM state.
- `fault_count`, out, 8: injected faults, saturating at 255.
- `viol`, out, 1: sticky violation flag.
- `viol_code`, out, 3: code of the first violation.

## Operation
- **Region hit, bus access:** byte `(bus_addr + i) mod 2^XLEN`, for `i < BUSLEN/8`, lies in `[fault_base, fault_base + REGION_BYTES)`, computed modulo 2^XLEN. The byte must be enabled in the access's rmask or wmask.
- **Region hit, retire:** same range test on `(rvfi_mem_addr + j) mod 2^XLEN`, for `j < XLEN/8`, with the byte enabled in rmask or wmask.
- **`fault_req[c]`:** asserted when bus channel `c` is a valid data access, hits the region, and either:
  - `MODE == 0`; or
  - `MODE == 1` and `state == IDLE` and no lower-indexed channel already hits this cycle.
- **`bus_hit`:** any channel with `fault_req` set and `rvfi_bus_fault` set.
- FSM states:
  - `IDLE` (0): `bus_hit` → `PENDING`.
  - `PENDING` (1): first qualifying retire → `IDLE` if `MODE == 0`, → `SPENT` if `MODE == 1`. Timeout → `SPENT`.
  - `SPENT` (2): absorbing until reset.
- **Qualifying retire:** `rvfi_valid[k]` and `check` and a region hit. Only the lowest such `k` is evaluated per cycle.
- **A retire is required to trap when** it is qualifying and either:
  - `MODE == 0` (any state); or
  - `MODE == 1` and the effective state is `PENDING`.
- **Requirement on a required trap:**
  - `rvfi_trap` = 1.
  - If `CHECK_MEM_FAULT`: `rvfi_mem_fault` = 1.
  - If `CHECK_MCAUSE`: mcause wmask all ones, and wdata 7 if any wmask byte in the region hits (wmask has priority), else 5.
- **Violation codes:**
  - 1: trap missing.
  - 2: mem_fault missing.
  - 3: mcause wrong.
  - 4: timeout.
  - If several coincide, the lowest code wins.
  - `viol` is set and `viol_code` is captured only on the first violation; both hold until reset.
  - Each violation also fires the corresponding `assert`.
- **Coverage:** a `cover` fires on each required-trap retire.
- **`fault_count`:** increments by 1 per cycle with `bus_hit` (multiple channels in one cycle count as 1); saturates at 255.

## Timing
- **Reset** (synchronous, sampled on `posedge clock`): `state` = IDLE, `fault_count` = 0, `viol` = 0, `viol_code` = 0, latency counter = 0. `fault_req` depends on inputs only. No checks run in a reset cycle.
- **Reset mid-PENDING:** state returns to IDLE next cycle; no timeout is reported.
- **Same-cycle bus and retire:** the bus hit is applied first. The effective state for retire evaluation is `PENDING` if `bus_hit` occurs from `IDLE` this cycle, so a same-cycle retire is required to trap.
- **Latency counter:**
  - Cleared on entry to `PENDING`; increments once per cycle while in `PENDING`.
  - If it reaches `MAX_LATENCY` with no qualifying retire: violation 4, state → `SPENT`.
  - Width is `clog2(MAX_LATENCY+1)`; it never wraps.
- **Pipelining:** `state`, `fault_count` and `viol` update one cycle after the triggering event; `fault_req` has zero latency.

## Test plan
- **MODE=0 read fault:** `fault_base = 0x100`, REGION_BYTES = 4. Bus read `0x100` mask `0001`, then a retired load at `0x102` with `rvfi_trap` = 1 and mcause = 5 → `fault_req` = 1, `state` goes 0 → 1 → 0, `viol` stays 0, `fault_count` = 1.
- **MODE=0 write, wrong cause:** retired store at `0x100` with mcause = 5 → `viol` = 1, `viol_code` = 3.
- **MODE=1 fault-once:** first bus hit → `fault_req` = 1, `state` = 1. Second bus access to the region → `fault_req` = 0. Retire trapping with mcause 5 → `state` = 2. A later non-trapping retire to the region → no violation.
- **Timeout:** MODE=1, MAX_LATENCY = 3. Bus hit, then no retire for 3 cycles → `viol_code` = 4, `state` = 2.
- **Wrap-around:** `fault_base = 0xFFFFFFFC`. Bus access at `0xFFFFFFFE` with BUSLEN = 64 and all lanes enabled → `fault_req` = 1. Bus access at `0x00000000` → `fault_req` = 0.
- **Same-cycle bus and retire:** MODE=1, bus hit and a non-trapping retire on channels 0/1 in one cycle → `viol_code` = 1. Reset next cycle → all outputs return to 0.

Source files
------------

// File: rtl/rvfi_bus_dmem_fault_region_check.sv
// rvfi_bus_dmem_fault_region_check
//
// Fault-region checker for data-bus fault propagation in the riscv-formal harness.
// A region of REGION_BYTES starting at fault_base is the fault target. Bus accesses that
// touch the region are told to fault (fault_req). Every retire touching the region
// while a fault is outstanding must then trap with the matching mcause. In persistent
// mode (MODE 0) this applies to every retire that touches the region. In fault-once
// mode (MODE 1) it applies only to the retire that resolves the single injection.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   check                 enables retire checking this cycle
//   fault_base            region base (constant, aligned to REGION_BYTES)
//   rvfi_*                retire taps, NRET channels
//   rvfi_bus_*            bus taps, NBUS channels
//   fault_req             per bus channel: this access must fault (combinational)
//   state                 0 idle, 1 fault pending, 2 spent
//   fault_count           cycles with an injected fault, saturating at 255
//   viol, viol_code       sticky first violation: 1 no trap, 2 no mem_fault,
//                         3 wrong mcause, 4 retire latency exceeded
module rvfi_bus_dmem_fault_region_check #(
  parameter int unsigned NRET            = 1,
  parameter int unsigned NBUS            = 1,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned BUSLEN          = 32,
  parameter int unsigned REGION_BYTES    = 4,
  parameter int unsigned MODE            = 0,
  parameter int unsigned MAX_LATENCY     = 0,
  parameter bit          CHECK_MEM_FAULT = 1'b1,
  parameter bit          CHECK_MCAUSE    = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     check,
  input  logic [XLEN-1:0]          fault_base,
  input  logic [NRET-1:0]          rvfi_valid,
  input  logic [NRET-1:0]          rvfi_trap,
  input  logic [NRET-1:0]          rvfi_mem_fault,
  input  logic [NRET*XLEN-1:0]     rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask,
  input  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]     rvfi_csr_mcause_wmask,
  input  logic [NRET*XLEN-1:0]     rvfi_csr_mcause_wdata,
  input  logic [NBUS-1:0]          rvfi_bus_valid,
  input  logic [NBUS-1:0]          rvfi_bus_data,
  input  logic [NBUS-1:0]          rvfi_bus_fault,
  input  logic [NBUS*XLEN-1:0]     rvfi_bus_addr,
  input  logic [NBUS*BUSLEN/8-1:0] rvfi_bus_rmask,
  input  logic [NBUS*BUSLEN/8-1:0] rvfi_bus_wmask,
  output logic [NBUS-1:0]          fault_req,
  output logic [1:0]               state,
  output logic [7:0]               fault_count,
  output logic                     viol,
  output logic [2:0]               viol_code
);

  localparam int unsigned BusBytes  = BUSLEN / 8;
  localparam int unsigned XBytes    = XLEN / 8;
  localparam int unsigned LatW      = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1;
  localparam int unsigned LatLast   = (MAX_LATENCY > 0) ? MAX_LATENCY - 1 : 0;
  localparam bit          FaultOnce = (MODE == 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StSpent   = 2'd2
  } state_e;

  state_e          state_q;
  logic [LatW-1:0] lat_q;

  // Offset from the base, taken modulo 2^XLEN, makes the range test wrap-safe.
  function automatic logic in_region(input logic [XLEN-1:0] addr,
                                     input logic [XLEN-1:0] base);
    logic [XLEN-1:0] off;
    off = addr - base;
    return off < XLEN'(REGION_BYTES);
  endfunction

  // Bus side: which channels are data accesses touching the region.
  logic [NBUS-1:0] bus_region;

  for (genvar c = 0; c < NBUS; c++) begin : g_bus
    logic [BusBytes-1:0] byte_hit;
    for (genvar i = 0; i < BusBytes; i++) begin : g_byte
      assign byte_hit[i] = (rvfi_bus_rmask[c*BusBytes+i] | rvfi_bus_wmask[c*BusBytes+i]) &
                           in_region(rvfi_bus_addr[c*XLEN +: XLEN] + XLEN'(i), fault_base);
    end
    assign bus_region[c] = rvfi_bus_valid[c] & rvfi_bus_data[c] & (|byte_hit);
  end

  // Retire side: region touch and expected mcause per channel.
  logic [NRET-1:0] ret_region;
  logic [NRET-1:0] ret_mcause_ok;

  for (genvar k = 0; k < NRET; k++) begin : g_ret
    logic [XBytes-1:0] rd_hit;
    logic [XBytes-1:0] wr_hit;
    logic [XLEN-1:0]   cause_exp;
    for (genvar j = 0; j < XBytes; j++) begin : g_byte
      logic in_j;
      assign in_j      = in_region(rvfi_mem_addr[k*XLEN +: XLEN] + XLEN'(j), fault_base);
      assign rd_hit[j] = in_j & rvfi_mem_rmask[k*XBytes+j];
      assign wr_hit[j] = in_j & rvfi_mem_wmask[k*XBytes+j];
    end
    // Any store byte in the region makes it a store access fault (7), else load fault (5).
    assign cause_exp        = (|wr_hit) ? XLEN'(7) : XLEN'(5);
    assign ret_region[k]    = (|rd_hit) | (|wr_hit);
    assign ret_mcause_ok[k] = (rvfi_csr_mcause_wmask[k*XLEN +: XLEN] == {XLEN{1'b1}}) &&
                              (rvfi_csr_mcause_wdata[k*XLEN +: XLEN] == cause_exp);
  end

  // Fault injection. Fault-once picks only the lowest hitting channel, and only from idle.
  logic [NBUS-1:0] bus_first;
  logic            bus_hit;

  assign bus_first = bus_region & (~bus_region + NBUS'(1));
  assign fault_req = FaultOnce ? ((state_q == StIdle) ? bus_first : '0) : bus_region;
  assign bus_hit   = |(fault_req & rvfi_bus_fault);

  // Retire evaluation, lowest qualifying channel only.
  logic [NRET-1:0] ret_cand;
  logic [NRET-1:0] ret_sel;
  logic            qual;
  logic            eff_pending;
  logic            req_trap;
  logic            miss_trap;
  logic            miss_mf;
  logic            bad_cause;
  logic            timeout;
  logic [2:0]      viol_now;

  assign ret_cand    = rvfi_valid & {NRET{check}} & ret_region;
  assign ret_sel     = ret_cand & (~ret_cand + NRET'(1));
  assign qual        = |ret_cand;
  // An injection this cycle already counts as outstanding for a same-cycle retire.
  assign eff_pending = (state_q == StPending) || ((state_q == StIdle) && bus_hit);
  assign req_trap    = !reset && qual && (!FaultOnce || eff_pending);
  assign miss_trap   = |(ret_sel & ~rvfi_trap);
  assign miss_mf     = CHECK_MEM_FAULT && (|(ret_sel & ~rvfi_mem_fault));
  assign bad_cause   = CHECK_MCAUSE && (|(ret_sel & ~ret_mcause_ok));
  assign timeout     = !reset && (MAX_LATENCY != 0) && (state_q == StPending) && !qual &&
                       (lat_q == LatW'(LatLast));

  always_comb begin
    viol_now = 3'd0;
    if (req_trap) begin
      if (miss_trap) begin
        viol_now = 3'd1;
      end else if (miss_mf) begin
        viol_now = 3'd2;
      end else if (bad_cause) begin
        viol_now = 3'd3;
      end
    end else if (timeout) begin
      viol_now = 3'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      fault_count <= 8'd0;
      viol        <= 1'b0;
      viol_code   <= 3'd0;
    end else begin
      if (bus_hit && (fault_count != 8'hff)) begin
        fault_count <= fault_count + 8'd1;
      end
      if (!viol && (viol_now != 3'd0)) begin
        viol      <= 1'b1;
        viol_code <= viol_now;
      end
      case (state_q)
        StIdle: begin
          if (bus_hit) begin
            lat_q <= '0;
            // A same-cycle qualifying retire resolves the injection immediately.
            if (qual) begin
              state_q <= FaultOnce ? StSpent : StIdle;
            end else begin
              state_q <= StPending;
            end
          end
        end
        StPending: begin
          if (qual) begin
            state_q <= FaultOnce ? StSpent : StIdle;
          end else if (MAX_LATENCY != 0) begin
            lat_q <= lat_q + LatW'(1);
            if (timeout) begin
              state_q <= StSpent;
            end
          end
        end
        default: ;  // StSpent holds until reset
      endcase
    end
  end

  assign state = state_q;

`ifdef FORMAL
  always_comb begin
    if (req_trap) begin
      cover (1'b1);
      assert (!miss_trap);
      assert (!miss_mf);
      assert (!bad_cause);
    end
    assert (!timeout);
  end
`endif

endmodule
